// File: rtl/iserdes_dly_scan_pkg.sv
// Shared types for the DQ-lane read-capture delay scan: FSM state encoding
// and the default training pattern.
package iserdes_dly_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        REQ,
        SAMPLE,
        EVAL,
        CENTER,
        DONE
    } state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b0101;

endpackage

// File: rtl/iserdes_dly_scan_if.sv
// Bundle between the scan sequencer (slave) and the PHY control sequencer /
// IDELAY / ISERDES side (master), plus the scan FSM state for observation.
interface iserdes_dly_scan_if #(
    parameter int TAP_WIDTH = 5
);
    import iserdes_dly_scan_pkg::*;

    localparam int NTAPS = 1 << TAP_WIDTH;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 fail;
    logic [TAP_WIDTH-1:0] dly_tap;
    logic                 dly_set;
    // rd_req is a level held until rd_ack; the request is taken on the clock
    // edge where both are high, and rd_req drops the following cycle.
    logic                 rd_req;
    logic                 rd_ack;
    logic [3:0]           din;
    logic                 din_valid;
    logic [TAP_WIDTH-1:0] best_start;
    logic [TAP_WIDTH:0]   best_len;
    logic [NTAPS-1:0]     pass_map;
    state_e               dbg_state;

    modport slave (
        input  start, rd_ack, din, din_valid,
        output busy, done, fail, dly_tap, dly_set, rd_req,
               best_start, best_len, pass_map, dbg_state
    );

    modport master (
        output start, rd_ack, din, din_valid,
        input  busy, done, fail, dly_tap, dly_set, rd_req,
               best_start, best_len, pass_map, dbg_state
    );

endinterface

// File: rtl/iserdes_dly_scan_dly_window_tracker.sv
// Tracks the current run of passing taps and the longest run seen so far,
// and derives the centre tap of the best window.
module dly_window_tracker #(
    parameter int TAP_WIDTH = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 eval_i,
    input  logic                 pass_i,
    input  logic [TAP_WIDTH-1:0] tap_i,
    output logic [TAP_WIDTH-1:0] best_start_o,
    output logic [TAP_WIDTH:0]   best_len_o,
    output logic [TAP_WIDTH-1:0] centre_o
);

    localparam logic [TAP_WIDTH:0] LEN_ONE = (TAP_WIDTH+1)'(1);

    logic [TAP_WIDTH:0]   run_len_q, run_len_d;
    logic [TAP_WIDTH-1:0] run_start_q, run_start_d;
    logic [TAP_WIDTH:0]   best_len_q, best_len_d;
    logic [TAP_WIDTH-1:0] best_start_q, best_start_d;

    always_comb begin
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (clear_i) begin
            run_len_d    = '0;
            run_start_d  = '0;
            best_len_d   = '0;
            best_start_d = '0;
        end else if (eval_i) begin
            if (pass_i) begin
                run_len_d = run_len_q + LEN_ONE;
                if (run_len_q == '0) begin
                    run_start_d = tap_i;
                end
            end else begin
                run_len_d = '0;
            end
            // Strict compare: an equal-length later window never displaces the earlier one.
            if (run_len_d > best_len_q) begin
                best_len_d   = run_len_d;
                best_start_d = run_start_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else begin
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

    // The window never extends past the last tap, so the sum fits TAP_WIDTH bits.
    assign centre_o     = (best_len_q == '0) ? '0 :
                          TAP_WIDTH'({1'b0, best_start_q} + ((best_len_q - LEN_ONE) >> 1));
    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/iserdes_dly_scan.sv
// Read-capture delay scan for one DDR3 DQ lane: sweeps every IDELAY tap, checks a
// pattern burst per tap and centres on the longest passing window. ISERDES_DLY_SCAN_MAP_EN builds the pass_map register.
module iserdes_dly_scan
    import iserdes_dly_scan_pkg::*;
#(
    parameter int         TAP_WIDTH     = 5,
    parameter int         SAMPLE_WIDTH  = 4,
    parameter int         SETTLE_CYCLES = 8,
    parameter logic [3:0] PATTERN       = DEFAULT_PATTERN
) (
    input  logic           mclk,
    input  logic           mrst_n,
    iserdes_dly_scan_if.slave bus
);

    localparam int                      NTAPS       = 1 << TAP_WIDTH;
    localparam logic [TAP_WIDTH-1:0]    TAP_MAX     = '1;
    localparam logic [7:0]              SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_LAST = '1;

    state_e                  state_q, state_d;
    logic [TAP_WIDTH-1:0]    tap_q, tap_d;
    logic [7:0]              settle_q, settle_d;
    logic [SAMPLE_WIDTH-1:0] smp_q, smp_d;
    logic                    err_q, err_d;
    logic                    fail_q, fail_d;
    logic [TAP_WIDTH-1:0]    dly_tap_q, dly_tap_d;
    logic                    busy_q, done_q, dly_set_q, rd_req_q;
    logic                    scan_clear, eval_stb;
    logic [TAP_WIDTH-1:0]    best_start, centre;
    logic [TAP_WIDTH:0]      best_len;

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        settle_d   = settle_q;
        smp_d      = smp_q;
        err_d      = err_q;
        fail_d     = fail_q;
        dly_tap_d  = dly_tap_q;
        scan_clear = 1'b0;
        eval_stb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SET;
                    tap_d      = '0;
                    fail_d     = 1'b0;
                    scan_clear = 1'b1;
                end
            end
            SET: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = REQ;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            REQ: begin
                if (bus.rd_ack) begin
                    state_d = SAMPLE;
                    smp_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SAMPLE: begin
                if (bus.din_valid) begin
                    smp_d = smp_q + 1'b1;
                    if (bus.din != PATTERN) begin
                        err_d = 1'b1;
                    end
                    if (smp_q == SAMPLE_LAST) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                eval_stb = 1'b1;
                if (tap_q == TAP_MAX) begin
                    state_d = CENTER;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = SET;
                end
            end
            CENTER: begin
                state_d   = DONE;
                dly_tap_d = centre;
                if (best_len == '0) begin
                    fail_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The tap is registered alongside the SET strobe so both appear in the SET cycle.
        if (state_d == SET) begin
            dly_tap_d = tap_d;
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            settle_q  <= '0;
            smp_q     <= '0;
            err_q     <= 1'b0;
            fail_q    <= 1'b0;
            dly_tap_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dly_set_q <= 1'b0;
            rd_req_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            settle_q  <= settle_d;
            smp_q     <= smp_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            dly_tap_q <= dly_tap_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q == DONE);
            dly_set_q <= (state_d == SET) || (state_q == CENTER);
            rd_req_q  <= (state_d == REQ);
        end
    end

    dly_window_tracker #(
        .TAP_WIDTH (TAP_WIDTH)
    ) u_tracker (
        .clk_i        (mclk),
        .rst_ni       (mrst_n),
        .clear_i      (scan_clear),
        .eval_i       (eval_stb),
        .pass_i       (!err_q),
        .tap_i        (tap_q),
        .best_start_o (best_start),
        .best_len_o   (best_len),
        .centre_o     (centre)
    );

`ifdef ISERDES_DLY_SCAN_MAP_EN
    logic [NTAPS-1:0] map_q;

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            map_q <= '0;
        end else if (scan_clear) begin
            map_q <= '0;
        end else if (eval_stb) begin
            map_q[tap_q] <= !err_q;
        end
    end

    assign bus.pass_map = map_q;
`else
    assign bus.pass_map = {NTAPS{1'b0}};
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;
    assign bus.dly_tap    = dly_tap_q;
    assign bus.dly_set    = dly_set_q;
    assign bus.rd_req     = rd_req_q;
    assign bus.best_start = best_start;
    assign bus.best_len   = best_len;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/iserdes_dly_scan.md
# iserdes_dly_scan

Read-capture training sequencer for one DDR3 DQ lane on the 4:1 memory ISERDES path. It sweeps the lane's input delay tap across its full range and requests a known-pattern read burst at each tap. It checks every captured 4-bit word against the expected pattern, finds the longest contiguous passing tap window, and programs the delay to the window centre. It sits between the PHY control sequencer, which issues start and serves read requests, and the IDELAY tap load port plus ISERDES `dout` of one lane.

## Interface
Parameters:
- TAP_WIDTH, 5, delay tap width; the sweep covers taps 0..2^TAP_WIDTH-1.
- SAMPLE_WIDTH, 4, log2 of the number of valid words checked per tap (16).
- SETTLE_CYCLES, 8, idle cycles after each tap load before a read request; range 1..255.
- PATTERN, 4'b0101, expected ISERDES word for every sample.

Ports:
- mclk  in  1  system clock; all logic is on its rising edge.
- mrst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan; ignored while busy.
- busy  out  1  high from the cycle after start until the cycle done pulses.
- done  out  1  one-cycle pulse at scan end.
- fail  out  1  sticky until next start; set when no tap passed.
- dly_tap  out  TAP_WIDTH  tap value presented to the IDELAY.
- dly_set  out  1  one-cycle load strobe for dly_tap.
- rd_req  out  1  read-burst request; level; held until rd_ack.
- rd_ack  in  1  request accepted (same-cycle handshake).
- din  in  4  ISERDES `dout`.
- din_valid  in  1  din carries a read-data word.
- best_start  out  TAP_WIDTH  first tap of the best window.
- best_len  out  TAP_WIDTH+1  length of the best window (0..2^TAP_WIDTH).
- pass_map  out  2^TAP_WIDTH  per-tap pass bitmap; see Configuration.

## Operation
States:
- IDLE: on start, go to SET with tap=0; clear fail, the run and best registers, and pass_map.
- SET: assert dly_set for one cycle with dly_tap=tap, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to REQ.
- REQ: hold rd_req high. On the cycle rd_ack=1, drop rd_req, clear the sample counter and err, and go to SAMPLE.
- SAMPLE: each din_valid word increments the counter; din≠PATTERN sets err. After the 2^SAMPLE_WIDTH-th valid word, go to EVAL.
- EVAL (1 cycle): pass = !err.
  - Pass: run_len += 1; if run_len was 0, run_start = tap.
  - Fail: run_len = 0.
  - If the updated run_len > best_len, best updates to run_start/run_len. Strict >, so ties keep the earlier window.
  - If tap = max, go to CENTER; else tap += 1 and go to SET.
- CENTER: if best_len=0, set fail and use centre = 0. Otherwise centre = best_start + ((best_len-1)>>1), computed at TAP_WIDTH+1 bits, which cannot overflow. Load dly_tap=centre with a one-cycle dly_set, then go to DONE.
- DONE: pulse done, drop busy, go to IDLE.

Other rules:
- din_valid outside SAMPLE is ignored.
- Extra valid words arriving after the last sample are ignored.
- start while busy is ignored.
- The run window tracks wrap-free: tap max does not join tap 0.

## Timing
- Reset values: busy=0, done=0, fail=0, dly_set=0, rd_req=0, dly_tap=0, best_start=0, best_len=0, pass_map=0, state IDLE.
- Reset asserted mid-scan returns to IDLE immediately. No dly_set is issued; the IDELAY keeps whatever tap it last loaded.
- start at cycle 0: busy=1 and the first dly_set at cycle 1. rd_req rises at cycle 2+SETTLE_CYCLES.
- Per-tap overhead excluding the read wait: 1 (SET) + SETTLE_CYCLES + 1 (EVAL).
- The final dly_set and done are in consecutive cycles; outputs are registered.
- best_start and best_len are valid from done until the next start.

## Configuration
- ISERDES_DLY_SCAN_MAP_EN defined: pass_map bit[tap] is written with the pass result in EVAL.
- ISERDES_DLY_SCAN_MAP_EN undefined: the port is present but tied to 0, and no map register is built.
- Window detection is identical in both builds.

## Structure
- Package iserdes_dly_scan_pkg: state enum (IDLE, SET, SETTLE, REQ, SAMPLE, EVAL, CENTER, DONE) and the default PATTERN constant.
- Sub-module dly_window_tracker: run/best registers, the EVAL update, and the centre calculation. Inputs are clear, eval strobe, pass and tap. Outputs are best_start, best_len and centre.

## Test plan
- Pass taps 10..20, fail elsewhere -> best_start=10, best_len=11, final dly_tap=15, fail=0, 33 dly_set pulses total.
- Windows 3..5 and 20..27 -> best_start=20, best_len=8, final tap=23; pass_map=0x0FF00038 with the macro, 0 without.
- Equal windows 2..5 and 12..15 -> the earlier window wins: best_start=2, final tap=3.
- No tap passes -> fail=1, best_len=0, final dly_tap=0, done pulses once.
- rd_ack delayed 50 cycles at tap 7, plus din_valid pulses outside SAMPLE -> rd_req held the whole 50 cycles, the stray words are ignored, and results match a scan with no delay.
- mrst_n low during SAMPLE at tap 12 -> all outputs are 0 next cycle. A new start then rescans from tap 0 with correct results.
